// File: rtl/flit_fifo.sv
// flit_fifo: per-input-port flit buffer for the 2x2 mesh router.
// Circular buffer with registered output. Flags empty/full are decoded
// from the occupancy counter. Sticky overflow and underflow error flags.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            flit_type,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    // Occupancy value that means "every slot holds a flit".
    localparam logic [PTR_WIDTH:0] L_FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    // Flit storage. It is never reset, so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [PTR_WIDTH:0]    w_count_next;

    // Acceptance uses the pre-edge flags. A full FIFO therefore never
    // passes a write through in the same cycle as a read.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == L_FULL_COUNT);
    assign w_wr_accept = wr_en && !w_full;
    assign w_rd_accept = rd_en && !w_empty;

    // Next occupancy: it changes only when exactly one side is accepted.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_accept && !w_rd_accept) begin
            w_count_next = r_count + (PTR_WIDTH + 1)'(1);
        end else if (!w_wr_accept && w_rd_accept) begin
            w_count_next = r_count - (PTR_WIDTH + 1)'(1);
        end
    end

    // Storage write port. A rejected write leaves memory untouched.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, registered read data, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_rd_accept) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            r_count <= w_count_next;
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout      = r_dout;
    assign flit_type = r_dout[DATA_WIDTH-1 -: 3];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
